// File: rtl/fpga_robots_game_serial_rx_pkg.sv
// ---------------------------------------------------------------------------
// fpga_robots_game_serial_rx_pkg
//
// Shared definitions for the robots-game serial receiver: receiver state
// encoding, the oversampling constants that place samples mid-bit, and a
// small helper for assembling an LSB-first byte.
//
// Contents:
//   rx_state_t          receiver FSM states
//   DATA_BITS           payload bits per frame (8N1)
//   START_MID_PHASE     phase at which the start bit is re-checked
//   LAST_PHASE          last phase of an 8x oversampled bit cell
//   LAST_BIT            index of the final data bit
//   SYNC_RESET_VALUE    idle level of the serial line
//   shift_in_lsb_first  shifts a new bit into the MSB of the shift register
// ---------------------------------------------------------------------------
package fpga_robots_game_serial_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int         DATA_BITS        = 8;
    localparam logic [2:0] START_MID_PHASE  = 3'd3;
    localparam logic [2:0] LAST_PHASE       = 3'd7;
    localparam logic [2:0] LAST_BIT         = 3'(DATA_BITS - 1);
    localparam logic       SYNC_RESET_VALUE = 1'b1;

    // Bits arrive LSB first, so each new bit enters at the top and the
    // earlier bits move down; after DATA_BITS shifts bit 0 sits at the LSB.
    function automatic logic [DATA_BITS-1:0] shift_in_lsb_first(
        input logic [DATA_BITS-1:0] current,
        input logic                 bit_in
    );
        return {bit_in, current[DATA_BITS-1:1]};
    endfunction

endpackage

// File: rtl/fpga_robots_game_serial_rx_sync.sv
// ---------------------------------------------------------------------------
// fpga_robots_game_sync
//
// Multi-flop synchronizer for an asynchronous single-bit input. Flops reset
// to the serial line idle level so that reset never looks like a start edge.
//
// Parameters:
//   SYNC_STAGES  number of flops in the chain (2 or 3)
//   RESET_VALUE  value loaded into every flop while rst is high
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronized output (last flop of the chain)
// ---------------------------------------------------------------------------
module fpga_robots_game_sync
    import fpga_robots_game_serial_rx_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = SYNC_RESET_VALUE
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/fpga_robots_game_serial_rx.sv
// ---------------------------------------------------------------------------
// fpga_robots_game_serial_rx
//
// 8N1 serial receiver for the robots game, running on the 65MHz game clock
// with an 8x oversampling enable (baud8). The start bit is re-checked at its
// middle, every data bit and the stop bit are sampled mid-cell, and a low
// stop bit is reported as a framing error, after which the line must return
// high before another frame is accepted.
//
// Parameters:
//   SYNC_STAGES  flops used to synchronize rxd (2 or 3)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   baud8     in   single-cycle enable, 8 per bit time
//   rxd       in   asynchronous serial line, idle high
//   rx_byte   out  last correctly framed byte
//   rx_valid  out  one-cycle pulse, rx_byte just updated
//   rx_ferr   out  one-cycle pulse, stop bit sampled low
//   rx_busy   out  high whenever a frame is being received or awaited high
// ---------------------------------------------------------------------------
module fpga_robots_game_serial_rx
    import fpga_robots_game_serial_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud8,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 rx_ferr,
    output logic                 rx_busy
);

    logic                 rxs;

    rx_state_t            state;
    rx_state_t            state_next;
    logic [2:0]           phase;
    logic [2:0]           phase_next;
    logic [2:0]           bitcnt;
    logic [2:0]           bitcnt_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [DATA_BITS-1:0] rx_byte_next;
    logic                 rx_valid_next;
    logic                 rx_ferr_next;

    fpga_robots_game_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (SYNC_RESET_VALUE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    // State register and datapath registers. Reset wins over baud8 and
    // discards any partially received byte without producing a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= 3'd0;
            bitcnt   <= 3'd0;
            shreg    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            bitcnt   <= bitcnt_next;
            shreg    <= shreg_next;
            rx_byte  <= rx_byte_next;
            rx_valid <= rx_valid_next;
            rx_ferr  <= rx_ferr_next;
        end
    end

    // Next-state and datapath logic. Everything except the output pulses is
    // gated by baud8, so holding baud8 low freezes the receiver in place.
    // The phase counter places the start re-check 4 ticks after the edge
    // and every later sample 8 ticks after the previous one, which lands
    // each sample in the middle of its bit cell.
    always_comb begin
        state_next    = state;
        phase_next    = phase;
        bitcnt_next   = bitcnt;
        shreg_next    = shreg;
        rx_byte_next  = rx_byte;
        rx_valid_next = 1'b0;
        rx_ferr_next  = 1'b0;

        if (baud8) begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_next = ST_START;
                        phase_next = 3'd0;
                    end
                end

                ST_START: begin
                    if (phase == START_MID_PHASE) begin
                        phase_next = 3'd0;
                        if (rxs) begin
                            // Line went back high before mid-start: a glitch.
                            state_next = ST_IDLE;
                        end else begin
                            state_next  = ST_DATA;
                            bitcnt_next = 3'd0;
                        end
                    end else begin
                        phase_next = phase + 3'd1;
                    end
                end

                ST_DATA: begin
                    phase_next = phase + 3'd1;
                    if (phase == LAST_PHASE) begin
                        shreg_next  = shift_in_lsb_first(shreg, rxs);
                        bitcnt_next = bitcnt + 3'd1;
                        if (bitcnt == LAST_BIT) begin
                            state_next = ST_STOP;
                            phase_next = 3'd0;
                        end
                    end
                end

                ST_STOP: begin
                    phase_next = phase + 3'd1;
                    if (phase == LAST_PHASE) begin
                        phase_next = 3'd0;
                        if (rxs) begin
                            rx_byte_next  = shreg;
                            rx_valid_next = 1'b1;
                            state_next    = ST_IDLE;
                        end else begin
                            // A low stop bit may be a break; wait for the line
                            // to recover so a held-low line yields one error.
                            rx_ferr_next = 1'b1;
                            state_next   = ST_WAIT_HIGH;
                        end
                    end
                end

                ST_WAIT_HIGH: begin
                    if (rxs) begin
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    phase_next = 3'd0;
                end
            endcase
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule
